// File: rtl/dct_pkg.sv
// dct_pkg
//   Shared constants for the 8-point DCT/IDCT pipeline.
//   - Coefficient magnitudes a..g (scale 128).
//   - 8x8 coefficient-index and sign tables describing matrix C[k][n].
//   - Rounding constants (add 64, arithmetic shift by 7).
//   - saturate(): clamp a wide signed value to a w-bit signed range.
package dct_pkg;

  localparam int N_PT = 8;

  localparam int COEF_A = 64;
  localparam int COEF_B = 60;
  localparam int COEF_C = 56;
  localparam int COEF_D = 45;
  localparam int COEF_E = 36;
  localparam int COEF_F = 24;
  localparam int COEF_G = 12;

  localparam int ROUND_SHIFT = 7;
  localparam int ROUND_BIAS  = 64;

  typedef enum logic [2:0] {
    CI_A = 3'd0,
    CI_B = 3'd1,
    CI_C = 3'd2,
    CI_D = 3'd3,
    CI_E = 3'd4,
    CI_F = 3'd5,
    CI_G = 3'd6
  } coef_idx_e;

  // Magnitude index of C[k][n]; outer index is the row k.
  localparam coef_idx_e COEF_IDX [N_PT][N_PT] = '{
    '{CI_D, CI_D, CI_D, CI_D, CI_D, CI_D, CI_D, CI_D},
    '{CI_A, CI_C, CI_E, CI_G, CI_G, CI_E, CI_C, CI_A},
    '{CI_B, CI_F, CI_F, CI_B, CI_B, CI_F, CI_F, CI_B},
    '{CI_C, CI_G, CI_A, CI_E, CI_E, CI_A, CI_G, CI_C},
    '{CI_D, CI_D, CI_D, CI_D, CI_D, CI_D, CI_D, CI_D},
    '{CI_E, CI_A, CI_G, CI_C, CI_C, CI_G, CI_A, CI_E},
    '{CI_F, CI_B, CI_B, CI_F, CI_F, CI_B, CI_B, CI_F},
    '{CI_G, CI_E, CI_C, CI_A, CI_A, CI_C, CI_E, CI_G}
  };

  // 1 where C[k][n] is negative.
  localparam logic COEF_NEG [N_PT][N_PT] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}
  };

  function automatic int coef_val(coef_idx_e idx);
    case (idx)
      CI_A:    return COEF_A;
      CI_B:    return COEF_B;
      CI_C:    return COEF_C;
      CI_D:    return COEF_D;
      CI_E:    return COEF_E;
      CI_F:    return COEF_F;
      CI_G:    return COEF_G;
      default: return 0;
    endcase
  endfunction

  // Clamp v to [-2^(w-1), 2^(w-1)-1]; caller keeps the low w bits.
  function automatic logic signed [63:0] saturate(logic signed [63:0] v, int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dct_row_sum.sv
// dct_row_sum
//   Combinational reduction for one DCT output: sums eight signed products,
//   rounds half-up with an arithmetic shift and saturates to SIZE_OUT bits.
//   Ports:
//     prod_i  8 x SIZE_MULT signed products, term j at [j*SIZE_MULT +: SIZE_MULT]
//     y_o     SIZE_OUT signed rounded/saturated result
module dct_row_sum
  import dct_pkg::*;
#(
  parameter int SIZE_MULT = 16,
  parameter int SIZE_OUT  = 10
) (
  input  logic [N_PT*SIZE_MULT-1:0] prod_i,
  output logic [SIZE_OUT-1:0]       y_o
);

  localparam int SUM_W = SIZE_MULT + 3;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W:0]   rnd;

  // One extra bit keeps the bias addition from wrapping at the top of range.
  function automatic logic signed [SUM_W:0] round_shift(logic signed [SUM_W-1:0] s);
    logic signed [SUM_W:0] t;
    t = (SUM_W + 1)'(s) + (SUM_W + 1)'(ROUND_BIAS);
    return t >>> ROUND_SHIFT;
  endfunction

  always_comb begin
    sum = '0;
    for (int j = 0; j < N_PT; j++) begin
      sum = sum + SUM_W'($signed(prod_i[j*SIZE_MULT +: SIZE_MULT]));
    end
    rnd = round_shift(sum);
    y_o = SIZE_OUT'(saturate(64'(rnd), SIZE_OUT));
  end

endmodule

// File: rtl/dct_1d_pipe.sv
// dct_1d_pipe
//   Three-stage pipelined 8-point 1-D DCT / IDCT with valid/ready flow control.
//   S1 registers the input vector and its mode bits, S2 registers the 64
//   products (forward or transposed coefficient selection happens in front of
//   S2), S3 registers the rounded, saturated outputs.
//   Ports:
//     clk, rst (async, active-low), clear (sync flush of all in-flight vectors)
//     in_valid / in_ready, data_in (8 x SIZE signed), inv, approx_en
//     out_valid / out_ready, data_out (8 x SIZE_OUT signed)
//     out_idx (vector index within 8x8 block), out_last (out_idx == 7)
module dct_1d_pipe
  import dct_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int SIZE_OUT    = SIZE + 2,
  parameter int APPROX_BITS = 0,
  parameter int SIZE_MULT   = SIZE + 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_PT*SIZE-1:0]     data_in,
  input  logic                     inv,
  input  logic                     approx_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_PT*SIZE_OUT-1:0] data_out,
  output logic [2:0]               out_idx,
  output logic                     out_last
);

  // Clears the low APPROX_BITS of a product (floor in two's complement).
  localparam logic [SIZE_MULT-1:0] APX_MASK = {SIZE_MULT{1'b1}} << APPROX_BITS;

  logic advance;

  logic signed [SIZE-1:0]      x_in     [N_PT];
  logic                        vld_p0_q;
  logic signed [SIZE-1:0]      x_p0_q   [N_PT];
  logic                        inv_p0_q;
  logic                        apx_p0_q;

  logic signed [SIZE_MULT-1:0] prod_d    [N_PT][N_PT];
  logic signed [SIZE_MULT-1:0] prod_p1_q [N_PT][N_PT];
  logic                        vld_p1_q;

  logic [N_PT*SIZE_MULT-1:0]   prod_row [N_PT];
  logic [SIZE_OUT-1:0]         y_d      [N_PT];
  logic [SIZE_OUT-1:0]         y_p2_q   [N_PT];
  logic                        vld_p2_q;

  logic [2:0]                  idx_q;
  logic [2:0]                  idx_d;

  // The whole pipe moves together; only a held output can stall it.
  assign advance  = !vld_p2_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int n = 0; n < N_PT; n++) begin
      x_in[n] = data_in[n*SIZE +: SIZE];
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (vld_p2_q && out_ready) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      idx_q    <= 3'd0;
    end else if (clear) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      if (advance) begin
        vld_p0_q <= in_valid;
        vld_p1_q <= vld_p0_q;
        vld_p2_q <= vld_p1_q;
      end
      idx_q <= idx_d;
    end
  end

  // ---- S1: input vector and per-vector mode bits ----
  always_ff @(posedge clk) begin
    if (advance) begin
      x_p0_q   <= x_in;
      inv_p0_q <= inv;
      apx_p0_q <= approx_en;
    end
  end

  // Output o, term j always multiplies x[j]; the inverse reads the table
  // transposed, so only the coefficient lookup changes with the mode.
  always_comb begin
    coef_idx_e                   ci;
    logic                        neg;
    logic signed [SIZE_MULT-1:0] cv;
    logic signed [SIZE_MULT-1:0] p;
    ci  = CI_A;
    neg = 1'b0;
    cv  = '0;
    p   = '0;
    for (int o = 0; o < N_PT; o++) begin
      for (int j = 0; j < N_PT; j++) begin
        ci  = inv_p0_q ? COEF_IDX[j][o] : COEF_IDX[o][j];
        neg = inv_p0_q ? COEF_NEG[j][o] : COEF_NEG[o][j];
        cv  = SIZE_MULT'(coef_val(ci));
        p   = SIZE_MULT'(x_p0_q[j]) * cv;
        if (neg) begin
          p = -p;
        end
        if (apx_p0_q) begin
          p = p & $signed(APX_MASK);
        end
        prod_d[o][j] = p;
      end
    end
  end

  // ---- S2: product registers ----
  always_ff @(posedge clk) begin
    if (advance) begin
      prod_p1_q <= prod_d;
    end
  end

  always_comb begin
    for (int o = 0; o < N_PT; o++) begin
      prod_row[o] = '0;
      for (int j = 0; j < N_PT; j++) begin
        prod_row[o][j*SIZE_MULT +: SIZE_MULT] = prod_p1_q[o][j];
      end
    end
  end

  for (genvar o = 0; o < N_PT; o++) begin : g_row
    dct_row_sum #(
      .SIZE_MULT(SIZE_MULT),
      .SIZE_OUT (SIZE_OUT)
    ) u_row_sum (
      .prod_i(prod_row[o]),
      .y_o   (y_d[o])
    );
  end

  // ---- S3: rounded, saturated outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < N_PT; o++) begin
        y_p2_q[o] <= '0;
      end
    end else if (advance) begin
      y_p2_q <= y_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int o = 0; o < N_PT; o++) begin
      data_out[o*SIZE_OUT +: SIZE_OUT] = y_p2_q[o];
    end
  end

  assign out_valid = vld_p2_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == 3'd7);

endmodule

// File: tb/tb_dct_1d_pipe.sv
// tb_dct_1d_pipe
//   Scoreboard bench for dct_1d_pipe (SIZE=8, SIZE_OUT=8, APPROX_BITS=4).
//   Expected vectors are queued at acceptance and compared on each output
//   handshake together with the expected block index and last flag.
module tb_dct_1d_pipe;

  localparam int SIZE        = 8;
  localparam int SIZE_OUT    = 8;
  localparam int APPROX_BITS = 4;
  localparam int SIZE_MULT   = 16;
  localparam int VW          = 8 * SIZE_OUT;

  localparam int CM [8][8] = '{
    '{45,  45,  45,  45,  45,  45,  45,  45},
    '{64,  56,  36,  12, -12, -36, -56, -64},
    '{60,  24, -24, -60, -60, -24,  24,  60},
    '{56, -12, -64, -36,  36,  64,  12, -56},
    '{45, -45, -45,  45,  45, -45, -45,  45},
    '{36, -64,  12,  56, -56, -12,  64, -36},
    '{24, -60,  60, -24, -24,  60, -60,  24},
    '{12, -36,  56, -64,  64, -56,  36, -12}
  };

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [8*SIZE-1:0] data_in;
  logic              inv;
  logic              approx_en;
  logic              out_valid;
  logic              out_ready;
  logic [VW-1:0]     data_out;
  logic [2:0]        out_idx;
  logic              out_last;

  dct_1d_pipe #(
    .SIZE       (SIZE),
    .SIZE_OUT   (SIZE_OUT),
    .APPROX_BITS(APPROX_BITS),
    .SIZE_MULT  (SIZE_MULT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .inv      (inv),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [VW-1:0] sb_q[$];
  logic [VW-1:0] sb_exp;
  int            exp_idx = 0;
  int            lasts_seen = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack8(int v0, int v1, int v2, int v3,
                                        int v4, int v5, int v6, int v7);
    return {v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
  endfunction

  function automatic logic [VW-1:0] model(logic [63:0] xv, bit iv, bit ap);
    int            x [8];
    int            s;
    int            p;
    int            y;
    int            hi;
    int            lo;
    logic [VW-1:0] r;
    r  = '0;
    hi = (1 << (SIZE_OUT - 1)) - 1;
    lo = -(1 << (SIZE_OUT - 1));
    for (int n = 0; n < 8; n++) x[n] = int'($signed(xv[n*8 +: 8]));
    for (int o = 0; o < 8; o++) begin
      s = 0;
      for (int j = 0; j < 8; j++) begin
        p = iv ? CM[j][o] * x[j] : CM[o][j] * x[j];
        if (ap) p = p & ~((1 << APPROX_BITS) - 1);
        s += p;
      end
      y = (s + 64) >>> 7;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      r[o*SIZE_OUT +: SIZE_OUT] = SIZE_OUT'(y);
    end
    return r;
  endfunction

  // Drive one vector and wait (bounded) for it to be accepted.
  task automatic send(logic [63:0] xv, bit iv, bit ap, logic [VW-1:0] ex);
    int waited = 0;
    data_in   = xv;
    inv       = iv;
    approx_en = ap;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] xv;
    bit          iv;
    bit          ap;
    xv = {$urandom, $urandom};
    iv = 1'($urandom_range(0, 1));
    ap = 1'($urandom_range(0, 1));
    send(xv, iv, ap, model(xv, iv, ap));
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Output monitor: the scoreboard is flushed whenever the pipe is flushed.
  always @(negedge clk) begin
    if (!rst || clear) begin
      sb_q.delete();
      exp_idx = 0;
    end else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_output", out_valid, 0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_eq("data_out", data_out, sb_exp);
      end
      check_eq("out_idx", out_idx, exp_idx);
      check_eq("out_last", out_last, (exp_idx == 7));
      if (out_last) lasts_seen++;
      exp_idx = (exp_idx + 1) % 8;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] held;
    int            base;
    bit            stream_done;
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    inv       = 1'b0;
    approx_en = 1'b0;
    out_ready = 1'b1;
    stream_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Forward DC with latency check.
    send(pack8(10, 10, 10, 10, 10, 10, 10, 10), 0, 0, pack8(28, 0, 0, 0, 0, 0, 0, 0));
    check_eq("lat_cycle1", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_cycle2", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_cycle3", out_valid, 1);
    check_eq("first_idx", out_idx, 0);
    drain();

    // Directed values.
    send(pack8(100, 0, 0, 0, 0, 0, 0, 0), 0, 0, pack8(35, 50, 47, 44, 35, 28, 19, 9));
    send(pack8(-100, 0, 0, 0, 0, 0, 0, 0), 0, 0,
         pack8(-35, -50, -47, -44, -35, -28, -19, -9));
    send(pack8(127, 0, 0, 0, 0, 0, 0, 0), 1, 0, pack8(45, 45, 45, 45, 45, 45, 45, 45));
    send(pack8(127, 127, 127, 127, 127, 127, 127, 127), 0, 0, pack8(127, 0, 0, 0, 0, 0, 0, 0));
    send(pack8(-128, -128, -128, -128, -128, -128, -128, -128), 0, 0,
         pack8(-128, 0, 0, 0, 0, 0, 0, 0));
    send(pack8(1, 1, 1, 1, 1, 1, 1, 1), 0, 1, pack8(2, 0, 0, 0, 0, 0, 0, 0));
    send(pack8(1, 1, 1, 1, 1, 1, 1, 1), 0, 0, pack8(3, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // Random vectors with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Framing: 16 back-to-back vectors from a fresh index.
    pulse_clear();
    base = lasts_seen;
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    check_eq("last_count", lasts_seen - base, 2);

    // Backpressure: stall output for 5 cycles while streaming 4 vectors.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check_eq("bp_valid", out_valid, 1);
        held = data_out;
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_in_ready", in_ready, 0);
          check_eq("bp_valid_hold", out_valid, 1);
          check_eq("bp_data_stable", data_out, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Clear mid-stream.
    for (int i = 0; i < 3; i++) send_rand();
    pulse_clear();
    check_eq("clr_out_valid", out_valid, 0);
    check_eq("clr_out_idx", out_idx, 0);
    send_rand();
    drain();

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b0;
    #1;
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_data_out", data_out, 0);
    check_eq("mrst_out_idx", out_idx, 0);
    check_eq("mrst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("mrst_in_ready", in_ready, 1);
    send(pack8(10, 10, 10, 10, 10, 10, 10, 10), 0, 0, pack8(28, 0, 0, 0, 0, 0, 0, 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_1d_pipe.md
# dct_1d_pipe

Pipelined, parametrised 8-point 1-D DCT/IDCT stage with valid/ready flow control, per-vector forward/inverse mode and approximate-multiply mode. It sits between the block-row buffer and the transpose memory in the 2-D DCT path. Two instances (row pass, column pass) replace the combinational column stage. A 3-bit vector index and a last flag are supplied so downstream logic can frame 8x8 blocks.

## Interface
- SIZE, 8: signed input sample width
- SIZE_OUT, SIZE+2: signed output width; results saturate to this range
- APPROX_BITS, 0: low product bits zeroed when approx mode is on (0 = no effect)
- SIZE_MULT, SIZE+8: signed product width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush: drops all in-flight vectors, resets index
- in_valid  in  1  input vector valid
- in_ready  out  1  stage can accept
- data_in  in  8 x SIZE  signed samples x[0..7]
- inv  in  1  0 = forward DCT, 1 = inverse (transposed matrix); sampled with vector
- approx_en  in  1  approximate products for this vector; sampled with vector
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- data_out  out  8 x SIZE_OUT  signed results y[0..7]
- out_idx  out  3  vector index within block (0..7)
- out_last  out  1  high when out_idx == 7

## Operation
- Coefficients: a=64 b=60 c=56 d=45 e=36 f=24 g=12 (scale 128).
- Matrix C rows k=0..7, columns n=0..7:
  - row0: d d d d d d d d
  - row1: a c e g -g -e -c -a
  - row2: b f -f -b -b -f f b
  - row3: c -g -a -e e a g -c
  - row4: d -d -d d d -d -d d
  - row5: e -a g c -c -g a -e
  - row6: f -b b -f -f b -b f
  - row7: g -e c -a a -c e -g
- Forward: y[k] = sum_n C[k][n]*x[n]. Inverse: y[n] = sum_k C[k][n]*x[k].
- Products are signed, SIZE_MULT bits. With approx_en=1, the low APPROX_BITS bits of each product are forced to 0 (floor truncation in two's complement).
- Sum width is SIZE_MULT+3. Rounding: y = (sum + 64) >>> 7 (arithmetic shift).
- Saturation: the result is clamped to [-2^(SIZE_OUT-1), 2^(SIZE_OUT-1)-1].
- Index counter: increments on every output handshake (out_valid & out_ready) and wraps 7 -> 0. out_last = (out_idx == 7).

## Timing
- The pipeline has 3 register stages: S1 captures input, inv and approx_en; S2 registers the 64 products; S3 registers the rounded, saturated outputs.
- Latency: an accepted vector appears on out_valid 3 cycles after acceptance, provided there is no stall.
- Global advance = !out_valid | out_ready, and in_ready = advance.
- Input is accepted on in_valid & in_ready. Stage valids shift only when advance is high. Bubbles propagate as invalid stages.
- While out_valid=1 and out_ready=0: all stages hold, data_out stays stable, and in_ready=0.
- Throughput is 1 vector/cycle when out_ready is held high.
- clear (synchronous) has priority over handshakes: all stage valids go to 0 and out_idx goes to 0 next cycle. An input offered in the same cycle is dropped.
- Reset values: out_valid=0, data_out=0, out_idx=0, out_last=0, all stage valids 0. in_ready=1 after reset.
- Reset asserted mid-stream discards every in-flight vector.

## Structure
- Package dct_pkg holds:
  - coefficient constants a..g
  - 8x8 coefficient-index and sign tables
  - ROUND_SHIFT=7 and ROUND_BIAS=64
  - a saturate function
- Sub-module dct_row_sum: combinational 8-input signed sum plus round and saturate for one output. It is instantiated 8 times between S2 and S3.
- The mode mux (forward vs transposed table selection) is placed before the S2 product registers.

## Test plan
- Reset then forward DC: SIZE=8, all x=10, inv=0 -> y = 28,0,0,0,0,0,0,0 three cycles after accept. out_idx=0.
- Forward impulse: x0=100, others 0 -> 35,50,47,44,35,28,19,9. With x0=-100 -> -35,-50,-47,-44,-35,-28,-19,-9.
- Inverse DC and saturation:
  - X0=127, inv=1 -> all y=45.
  - Forward, all x=127, SIZE_OUT=8 -> y0 saturates to 127.
- Approx mode: APPROX_BITS=4, all x=1, forward. approx_en=1 -> y0=2; approx_en=0 -> y0=3.
- Backpressure: stream 4 vectors with out_ready low for 5 cycles -> in_ready=0 while stalled, no loss or reorder, data_out stable during the stall.
- Framing and flush:
  - 16 back-to-back vectors -> out_last on the 8th and 16th outputs.
  - clear pulsed mid-stream -> out_valid=0 next cycle and the next output has out_idx=0.
  - rst pulsed mid-stream -> all outputs return to their reset values.
